// File: rtl/mem_access_if.sv
// Data-memory request/response channel used by mem_access.
// The master drives the request side and the slave returns dm_ack and dm_rdata.
interface mem_access_if;
    logic        dm_req;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (output dm_req, dm_wen, dm_addr, dm_wdata, input dm_ack, dm_rdata);
    modport slave  (input dm_req, dm_wen, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues one data-memory access per load/store and aligns load/store data.
// Optional alignment exceptions are enabled by defining MEM_ADDR_CHECK_EN.
module mem_access (
    input  logic               clk,
    input  logic               resetn,
    input  logic               MEM_valid,
    input  logic               MEM_accept,
    input  logic [158:0]       EXE_MEM_bus_r,
    mem_access_if.master       dm,
    output logic               MEM_over,
    output logic [4:0]         MEM_wdest,
    output logic [122:0]       MEM_WB_bus,
    output logic [31:0]        MEM_pc
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [31:0] load_data;

    logic [4:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic [15:0] misc_fields;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
    logic [3:0]  tail_fields;

    assign {mem_control, store_data, exe_result, lo_result, misc_fields,
            rf_wen, rf_wdest, pc, tail_fields} = EXE_MEM_bus_r;

    logic is_load, is_store, is_word, is_half, sign_ext, mem_op, addr_exc;

    assign is_load  = mem_control[4];
    assign is_store = mem_control[3];
    assign is_word  = mem_control[2];
    assign is_half  = mem_control[1];
    assign sign_ext = mem_control[0];
    assign mem_op   = is_load | is_store;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_exc = mem_op & ((is_word & (|exe_result[1:0])) |
                                (~is_word & is_half & exe_result[0]));
`else
    assign addr_exc = 1'b0;
`endif

    logic [3:0]  wen_next;
    logic [31:0] wdata_next;

    always_comb begin
        wen_next   = '0;
        wdata_next = store_data;
        if (is_word) begin
            wen_next   = '1;
            wdata_next = store_data;
        end else if (is_half) begin
            wen_next   = exe_result[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{store_data[15:0]}};
        end else begin
            wen_next   = 4'b0001 << exe_result[1:0];
            wdata_next = {4{store_data[7:0]}};
        end
        if (is_load)
            wen_next = '0;
    end

    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] load_value;
    logic [31:0] mem_result;

    always_comb begin
        ld_half = exe_result[1] ? load_data[31:16] : load_data[15:0];
        case (exe_result[1:0])
            2'd0:    ld_byte = load_data[7:0];
            2'd1:    ld_byte = load_data[15:8];
            2'd2:    ld_byte = load_data[23:16];
            default: ld_byte = load_data[31:24];
        endcase
        if (is_word)
            load_value = load_data;
        else if (is_half)
            load_value = {{16{sign_ext & ld_half[15]}}, ld_half};
        else
            load_value = {{24{sign_ext & ld_byte[7]}}, ld_byte};
        mem_result = is_load ? load_value : exe_result;
    end

    // Request fields are latched at issue so they stay stable for the whole REQ phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            load_data   <= '0;
            dm.dm_req   <= 1'b0;
            dm.dm_wen   <= '0;
            dm.dm_addr  <= '0;
            dm.dm_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_valid & mem_op & ~addr_exc) begin
                        state       <= REQ;
                        dm.dm_req   <= 1'b1;
                        dm.dm_wen   <= wen_next;
                        dm.dm_addr  <= {exe_result[31:2], 2'b00};
                        dm.dm_wdata <= wdata_next;
                    end
                end
                REQ: begin
                    if (dm.dm_ack) begin
                        state     <= DONE;
                        dm.dm_req <= 1'b0;
                        dm.dm_wen <= '0;
                        if (is_load)
                            load_data <= dm.dm_rdata;
                    end
                end
                DONE: begin
                    if (MEM_accept | ~MEM_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MEM_over   = resetn & MEM_valid & ((state == DONE) | ~mem_op | addr_exc);
    assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
    assign MEM_pc     = pc;
    assign MEM_WB_bus = {rf_wen & ~addr_exc, rf_wdest, mem_result, lo_result, misc_fields,
                         pc, tail_fields, addr_exc};
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 MEM_valid  input  1  MEM stage holds a valid instruction.
REQ-004 MEM_accept  input  1  one-cycle pulse; a new instruction is loaded into the MEM register this cycle.
REQ-005 EXE_MEM_bus_r  input  159  registered EXE->MEM bus, MSB first: mem_control[4:0], store_data[31:0], exe_result[31:0], lo_result[31:0], hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0], syscall, eret, rf_wen, rf_wdest[4:0], pc[31:0], br, flagout, notinst, ri.
REQ-006 mem_control bits: [4]=load, [3]=store, [2]=word, [1]=half, [0]=sign-extend; neither word nor half = byte.
REQ-007 dm_req  output  1  data-memory request, held until dm_ack.
REQ-008 dm_wen  output  4  byte write enables; 0000 for loads.
REQ-009 dm_addr  output  32  {exe_result[31:2],2'b00}.
REQ-010 dm_wdata  output  32  aligned store data.
REQ-011 dm_ack  input  1  memory completes the request this cycle.
REQ-012 dm_rdata  input  32  read data, valid when dm_ack=1.
REQ-013 MEM_over  output  1  MEM work complete, may advance to WB.
REQ-014 MEM_wdest  output  5  rf_wdest & {5{MEM_valid}}, for hazard detection.
REQ-015 MEM_WB_bus  output  123  {rf_wen, rf_wdest, mem_result[31:0], lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, pc, br, flagout, notinst, ri, addr_exc}.
REQ-016 MEM_pc  output  32  pc field, for display.

Function
REQ-017 FSM states: IDLE, REQ, DONE; reset state IDLE.
REQ-018 IDLE->REQ when MEM_valid & (load|store) & ~addr_exc; dm_req=1 only in REQ.
REQ-019 REQ: dm_addr, dm_wen and dm_wdata stay stable; REQ->DONE on the cycle dm_ack=1; dm_ack may arrive in the first REQ cycle.
REQ-020 Load: dm_rdata is captured into the 32-bit load_data register on the dm_ack cycle; dm_rdata is ignored in all other cycles.
REQ-021 DONE->IDLE on MEM_accept or ~MEM_valid; otherwise DONE holds; no second request is issued for the same instruction.
REQ-022 MEM_over = MEM_valid & (state==DONE | ~(load|store) | addr_exc); non-memory instructions complete combinationally with zero added cycles.
REQ-023 Store enables: word 1111; half addr[1] ? 1100 : 0011, data {2{sd[15:0]}}; byte 0001<<addr[1:0], data {4{sd[7:0]}}.
REQ-024 Load result: word = load_data; half = load_data[16*addr[1]+:16]; byte = load_data[8*addr[1:0]+:8]; sign- or zero-extended to 32 bits per bit [0].
REQ-025 mem_result = load ? extracted load data : exe_result.
REQ-026 MEM_accept while in REQ is a protocol error; the FSM shall ignore it and remain in REQ until dm_ack.

Reset
REQ-027 resetn low at any time: state=IDLE, load_data=0, dm_req=0, dm_wen=0, and MEM_over=0 irrespective of MEM_valid; any in-flight request is dropped.
REQ-028 After resetn deasserts, dm_ack is ignored until a new request is issued.

Configuration
REQ-029 Macro MEM_ADDR_CHECK_EN defined: addr_exc=1 for a word access with addr[1:0]!=0 or a half access with addr[0]!=0; no request is issued, the written rf_wen is forced 0, and MEM_over asserts in the same cycle.
REQ-030 Macro MEM_ADDR_CHECK_EN undefined: addr_exc is tied 0; word accesses ignore addr[1:0] and half accesses ignore addr[0].

Verification
REQ-031 Non-memory instruction with exe_result=0x1234 and MEM_valid=1 -> MEM_over=1 in the same cycle, dm_req=0, mem_result=0x1234.
REQ-032 lw at 0x100, dm_ack 3 cycles after dm_req -> dm_req held with addr 0x100 for 3 cycles, MEM_over the cycle after dm_ack, mem_result=dm_rdata.
REQ-033 lb at 0x103 with rdata=0x80FF_FF11, sign-extend set -> mem_result=0xFFFF_FF80; same access as lbu -> 0x0000_0080.
REQ-034 sh at 0x202 with store_data=0xABCD -> dm_wen=1100, dm_wdata=0xABCD_ABCD, dm_addr=0x200.
REQ-035 resetn pulsed low while in REQ -> dm_req=0 immediately; a later dm_ack causes no state change and MEM_over stays 0.
REQ-036 With MEM_ADDR_CHECK_EN defined, lw at 0x102 -> addr_exc=1, dm_req=0, rf_wen=0 in MEM_WB_bus, MEM_over=1 in the same cycle.
